// File: rtl/qbus_pkg.sv
// rtl/qbus_pkg.sv - shared types and constants for the MPI bus master
package qbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ASYNC,
        ST_DATA,
        ST_TERM,
        ST_DONE,
        ST_ABORT
    } qbus_st_t;

    // Released levels of the active-low bus lines
    localparam logic        STROBE_OFF  = 1'b1;
    localparam logic [15:0] AD_RELEASED = 16'hFFFF;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic        bsel;
    } qbus_req_t;

endpackage

// File: rtl/qbus_rr_arb.sv
// rtl/qbus_rr_arb.sv - two-way round-robin grant with priority pointer
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   req[1:0]     request levels
//   grant_en     master is able to accept a grant this cycle (pointer moves only then)
//   grant_valid  some request is present
//   grant_idx    index of the winning requester
module qbus_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_valid,
    output logic       grant_idx
);

    // ptr holds the index that wins a tie, i.e. the one not served last
    logic ptr;

    always_comb begin
        grant_valid = |req;
        grant_idx   = 1'b0;
        if (req == 2'b11) begin
            grant_idx = ptr;
        end else if (req[1]) begin
            grant_idx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (grant_en && grant_valid) begin
            ptr <= ~grant_idx;
        end
    end

endmodule

// File: rtl/qbus_master_arb.sv
// rtl/qbus_master_arb.sv - two-requester MPI bus master with round-robin arbitration and reply timeout
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req, we, bsel                  per-requester request level, 1=write, 1=byte access
//   addr0/addr1, wdata0/wdata1     per-requester byte address and lane-placed write data
//   ack, err, rdata                completion pulse, timeout flag, read data (held until next ack)
//   ad_n_o, ad_n_oe, ad_n_i        inverted address/data bus drive, enable and sample
//   sync_n, din_n, dout_n, wtbt_n  active-low bus strobes
//   rply_n                         active-low slave reply, asynchronous
module qbus_master_arb
    import qbus_pkg::*;
#(
    parameter int SETUP   = 1,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [1:0]  bsel,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic [1:0]  ack,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] ad_n_o,
    output logic        ad_n_oe,
    input  logic [15:0] ad_n_i,
    output logic        sync_n,
    output logic        din_n,
    output logic        dout_n,
    output logic        wtbt_n,
    input  logic        rply_n
);

    qbus_st_t  state, state_nxt;
    qbus_req_t req_q;
    logic      grant_q;
    logic [3:0] setup_cnt;
    logic [7:0] to_cnt;
    logic      rply_m, rply_s;
    logic      arb_en, arb_valid, arb_idx;
    logic      timed_out;

    qbus_rr_arb u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant_en    (arb_en),
        .grant_valid (arb_valid),
        .grant_idx   (arb_idx)
    );

    assign timed_out = (to_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            grant_q   <= 1'b0;
            setup_cnt <= '0;
            to_cnt    <= '0;
            rply_m    <= 1'b1;
            rply_s    <= 1'b1;
            rdata     <= '0;
        end else begin
            state  <= state_nxt;
            rply_m <= rply_n;
            rply_s <= rply_m;

            if (state == ST_IDLE && arb_valid) begin
                grant_q <= arb_idx;
                req_q   <= arb_idx ? {addr1, wdata1, we[1], bsel[1]}
                                   : {addr0, wdata0, we[0], bsel[0]};
            end

            if (state == ST_ADDR) begin
                setup_cnt <= setup_cnt + 4'd1;
            end else begin
                setup_cnt <= '0;
            end

            // Restarts whenever a wait state is entered, so DATA and TERM each get a full budget
            if ((state == ST_DATA || state == ST_TERM) && state_nxt == state) begin
                to_cnt <= to_cnt + 8'd1;
            end else begin
                to_cnt <= '0;
            end

            if (state == ST_DATA && !req_q.we && !rply_s) begin
                rdata <= ~ad_n_i;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        arb_en    = 1'b0;
        sync_n    = STROBE_OFF;
        din_n     = STROBE_OFF;
        dout_n    = STROBE_OFF;
        wtbt_n    = STROBE_OFF;
        ad_n_oe   = 1'b0;
        ad_n_o    = AD_RELEASED;
        ack       = 2'b00;
        err       = 1'b0;

        case (state)
            ST_IDLE: begin
                arb_en = 1'b1;
                if (arb_valid) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                ad_n_oe = 1'b1;
                ad_n_o  = ~req_q.addr;
                wtbt_n  = ~req_q.we;
                if (setup_cnt == 4'(SETUP - 1)) state_nxt = ST_ASYNC;
            end
            ST_ASYNC: begin
                // Address held for one more cycle after sync_n falls
                ad_n_oe   = 1'b1;
                ad_n_o    = ~req_q.addr;
                wtbt_n    = ~req_q.we;
                sync_n    = 1'b0;
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                sync_n = 1'b0;
                if (req_q.we) begin
                    ad_n_oe = 1'b1;
                    ad_n_o  = ~req_q.wdata;
                    wtbt_n  = ~req_q.bsel;
                    dout_n  = 1'b0;
                end else begin
                    din_n = 1'b0;
                end
                if (!rply_s) begin
                    state_nxt = ST_TERM;
                end else if (timed_out) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_TERM: begin
                sync_n = 1'b0;
                if (req_q.we) begin
                    ad_n_oe = 1'b1;
                    ad_n_o  = ~req_q.wdata;
                    wtbt_n  = ~req_q.bsel;
                end
                if (rply_s) begin
                    state_nxt = ST_DONE;
                end else if (timed_out) begin
                    state_nxt = ST_ABORT;
                end
            end
            ST_DONE: begin
                ack[grant_q] = 1'b1;
                state_nxt    = ST_IDLE;
            end
            ST_ABORT: begin
                ack[grant_q] = 1'b1;
                err          = 1'b1;
                state_nxt    = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
